// File: rtl/load_store_unit.sv
// Serialises one 8/16/32/64-bit load or store into byte accesses on a byte-wide data memory.
// Optional MISALIGN_CHECK_EN rejects requests whose address is not a multiple of the access size.
module load_store_unit #(
   parameter int ADDR_WIDTH = 64
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_write,
   input  logic [1:0]            i_req_size,
   input  logic                  i_req_unsigned,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic [63:0]           i_req_wdata,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [7:0]            o_mem_wdata,
   output logic                  o_mem_we,
   output logic                  o_mem_re,
   input  logic [7:0]            i_mem_rdata,
   output logic                  o_resp_valid,
   output logic [63:0]           o_resp_rdata,
   output logic                  o_resp_error
);

   // state  | meaning
   // IDLE   | ready for a request
   // ACCESS | one byte access per cycle, r_cnt selects the byte
   // RESP   | one-cycle response pulse
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [2:0]            r_cnt;
   logic                  r_write;
   logic                  r_unsigned;
   logic                  r_error;
   logic [1:0]            r_size;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [63:0]           r_wdata;
   logic [63:0]           r_result;
   logic [2:0]            w_last_idx;
   logic                  w_misalign;
   logic                  w_sx;
   logic [63:0]           w_ext;

   // Index of the final byte: N-1 for N = 1 << size.
   assign w_last_idx = {r_size[1] & r_size[0], r_size[1], r_size[1] | r_size[0]};

`ifdef MISALIGN_CHECK_EN
   logic [2:0] w_req_mask;
   assign w_req_mask = {i_req_size[1] & i_req_size[0], i_req_size[1], i_req_size[1] | i_req_size[0]};
   assign w_misalign = |(i_req_addr[2:0] & w_req_mask);
`else
   assign w_misalign = 1'b0;
`endif

   assign w_sx = ~r_unsigned;

   always_comb begin
      w_ext = r_result;
      case (r_size)
         2'd0:    w_ext = {{56{w_sx & r_result[7]}},  r_result[7:0]};
         2'd1:    w_ext = {{48{w_sx & r_result[15]}}, r_result[15:0]};
         2'd2:    w_ext = {{32{w_sx & r_result[31]}}, r_result[31:0]};
         default: w_ext = r_result;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      o_req_ready  = 1'b0;
      o_mem_addr   = '0;
      o_mem_wdata  = 8'h00;
      o_mem_we     = 1'b0;
      o_mem_re     = 1'b0;
      o_resp_valid = 1'b0;
      o_resp_rdata = 64'h0;
      o_resp_error = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) w_state_nxt = w_misalign ? S_RESP : S_ACCESS;
         end
         S_ACCESS: begin
            o_mem_addr = r_addr + ADDR_WIDTH'(r_cnt);
            if (r_write) begin
               o_mem_we    = 1'b1;
               o_mem_wdata = r_wdata[{r_cnt, 3'b000} +: 8];
            end else begin
               o_mem_re = 1'b1;
            end
            if (r_cnt == w_last_idx) w_state_nxt = S_RESP;
         end
         S_RESP: begin
            o_resp_valid = 1'b1;
            o_resp_error = r_error;
            o_resp_rdata = (r_write || r_error) ? 64'h0 : w_ext;
            w_state_nxt  = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // Reset masks the outputs immediately so an in-flight store cannot land at the reset edge.
      if (i_reset) begin
         o_req_ready  = 1'b1;
         o_mem_addr   = '0;
         o_mem_wdata  = 8'h00;
         o_mem_we     = 1'b0;
         o_mem_re     = 1'b0;
         o_resp_valid = 1'b0;
         o_resp_rdata = 64'h0;
         o_resp_error = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt      <= 3'd0;
         r_write    <= 1'b0;
         r_size     <= 2'd0;
         r_unsigned <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= 64'h0;
         r_result   <= 64'h0;
         r_error    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_write    <= i_req_write;
                  r_size     <= i_req_size;
                  r_unsigned <= i_req_unsigned;
                  r_addr     <= i_req_addr;
                  r_wdata    <= i_req_wdata;
                  r_cnt      <= 3'd0;
                  r_result   <= 64'h0;
                  r_error    <= w_misalign;
               end
            end
            S_ACCESS: begin
               r_cnt <= r_cnt + 3'd1;
               if (!r_write) r_result[{r_cnt, 3'b000} +: 8] <= i_mem_rdata;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single requests plus reset-abort and back-to-back sequences.
module tb_load_store_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [63:0] req_addr, req_wdata;
   logic [63:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        mem_we, mem_re;
   logic        resp_valid, resp_error;
   logic [63:0] resp_rdata;

   logic [7:0]  mem [0:63];
   logic        pre_we = 1'b0;
   logic [5:0]  pre_addr = 6'd0;
   logic [7:0]  pre_data = 8'h00;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_WIDTH(64)) dut (
      .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_write(req_write), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .o_mem_we(mem_we), .o_mem_re(mem_re), .i_mem_rdata(mem_rdata),
      .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_error(resp_error)
   );

   // 64-byte memory model aliased over the address space (wrap lands at index 63 -> 0).
   assign mem_rdata = mem[mem_addr[5:0]];
   always @(posedge clk) begin
      if (mem_we)      mem[mem_addr[5:0]] <= mem_wdata;
      else if (pre_we) mem[pre_addr] <= pre_data;
   end

   typedef struct {
      string       name;
      logic        wr;
      logic [1:0]  sz;
      logic        uns;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
      int          exp_we;
      int          exp_re;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [5:0] a, input logic [7:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int lat, we_n, re_n, k;
      logic got, bad_flags, addr_ok;
      logic [63:0] rd;
      logic er;
      lat = 0; we_n = 0; re_n = 0; k = 0; got = 1'b0; bad_flags = 1'b0; addr_ok = 1'b1;
      rd = 64'hx; er = 1'bx;
      @(negedge clk);
      check({v.name, " ready"}, {63'h0, req_ready}, 64'h1);
      req_valid = 1'b1; req_write = v.wr; req_size = v.sz; req_unsigned = v.uns;
      req_addr = v.addr; req_wdata = v.wdata;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_addr = 64'hDEAD_BEEF_0BAD_F00D; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      req_size = 2'd3; req_write = ~v.wr;
      for (int c = 1; c <= 20 && !got; c++) begin
         if (mem_we || mem_re) begin
            if (mem_addr !== v.addr + 64'(k)) addr_ok = 1'b0;
            k++;
         end
         if (mem_we) we_n++;
         if (mem_re) re_n++;
         if (req_ready || (mem_we && mem_re) || (resp_valid && (mem_we || mem_re))) bad_flags = 1'b1;
         if (resp_valid) begin
            got = 1'b1; lat = c; rd = resp_rdata; er = resp_error;
         end else begin
            @(negedge clk);
         end
      end
      check({v.name, " latency"}, 64'(lat), 64'(v.exp_lat));
      check({v.name, " rdata"}, rd, v.exp_rd);
      check({v.name, " error"}, {63'h0, er}, {63'h0, v.exp_err});
      check({v.name, " we_count"}, 64'(we_n), 64'(v.exp_we));
      check({v.name, " re_count"}, 64'(re_n), 64'(v.exp_re));
      check({v.name, " addr_seq"}, {63'h0, addr_ok}, 64'h1);
      check({v.name, " excl"}, {63'h0, bad_flags}, 64'h0);
      @(negedge clk);
      check({v.name, " pulse_end"}, {62'h0, resp_valid, req_ready}, 64'h1);
   endtask

   initial begin
      int first_ready, busy_access;
      logic [63:0] rsp1;

      vecs[0]  = '{"st_d8",   1'b1, 2'd3, 1'b0, 64'd8,  64'h1122334455667788, 64'h0, 1'b0, 9, 8, 0};
      vecs[1]  = '{"ld_ws0",  1'b0, 2'd2, 1'b0, 64'd0,  64'h0, 64'hFFFFFFFFE5F644E0, 1'b0, 5, 0, 4};
      vecs[2]  = '{"ld_wu0",  1'b0, 2'd2, 1'b1, 64'd0,  64'h0, 64'h00000000E5F644E0, 1'b0, 5, 0, 4};
      vecs[3]  = '{"ld_bs2",  1'b0, 2'd0, 1'b0, 64'd2,  64'h0, 64'hFFFFFFFFFFFFFFF6, 1'b0, 2, 0, 1};
      vecs[4]  = '{"ld_bu2",  1'b0, 2'd0, 1'b1, 64'd2,  64'h0, 64'h00000000000000F6, 1'b0, 2, 0, 1};
      vecs[5]  = '{"ld_hs0",  1'b0, 2'd1, 1'b0, 64'd0,  64'h0, 64'h00000000000044E0, 1'b0, 3, 0, 2};
      vecs[6]  = '{"ld_hs2",  1'b0, 2'd1, 1'b0, 64'd2,  64'h0, 64'hFFFFFFFFFFFFE5F6, 1'b0, 3, 0, 2};
      vecs[7]  = '{"ld_d8",   1'b0, 2'd3, 1'b1, 64'd8,  64'h0, 64'h1122334455667788, 1'b0, 9, 0, 8};
`ifdef MISALIGN_CHECK_EN
      vecs[8]  = '{"ld_ws2",  1'b0, 2'd2, 1'b0, 64'd2,  64'h0, 64'h0, 1'b1, 1, 0, 0};
      vecs[9]  = '{"ld_wrap", 1'b0, 2'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0, 1'b1, 1, 0, 0};
      vecs[12] = '{"st_w30",  1'b1, 2'd2, 1'b0, 64'd30, 64'h00000000A1B2C3D4, 64'h0, 1'b1, 1, 0, 0};
`else
      vecs[8]  = '{"ld_ws2",  1'b0, 2'd2, 1'b0, 64'd2,  64'h0, 64'hFFFFFFFF8201E5F6, 1'b0, 5, 0, 4};
      vecs[9]  = '{"ld_wrap", 1'b0, 2'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFE07F, 1'b0, 3, 0, 2};
      vecs[12] = '{"st_w30",  1'b1, 2'd2, 1'b0, 64'd30, 64'h00000000A1B2C3D4, 64'h0, 1'b0, 5, 4, 0};
`endif
      vecs[10] = '{"st_w24",  1'b1, 2'd2, 1'b0, 64'd24, 64'h123456789ABCDEF0, 64'h0, 1'b0, 5, 4, 0};
      vecs[11] = '{"ld_wu24", 1'b0, 2'd2, 1'b1, 64'd24, 64'h0, 64'h000000009ABCDEF0, 1'b0, 5, 0, 4};

      reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
      req_addr = 64'd8; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      check("rst_during", {resp_rdata[62:0] | mem_addr[62:0] | {55'h0, mem_wdata}, resp_rdata[63] | mem_addr[63]}, 64'h0);
      check("rst_flags", {58'h0, req_ready, resp_valid, resp_error, mem_we, mem_re, 1'b0}, 64'h20);
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_flags", {58'h0, req_ready, resp_valid, resp_error, mem_we, mem_re, 1'b0}, 64'h20);
      check("post_rst_rdata", resp_rdata, 64'h0);

      for (int i = 0; i < 64; i++) preload(6'(i), 8'h00);
      preload(6'd0, 8'hE0); preload(6'd1, 8'h44); preload(6'd2, 8'hF6); preload(6'd3, 8'hE5);
      preload(6'd4, 8'h01); preload(6'd5, 8'h82); preload(6'd6, 8'h33); preload(6'd7, 8'h44);
      preload(6'd63, 8'h7F);

      for (int i = 0; i < 13; i++) run_vec(vecs[i]);

      check("mem8_15", {mem[15], mem[14], mem[13], mem[12], mem[11], mem[10], mem[9], mem[8]},
            64'h1122334455667788);
      check("mem24_28", {24'h0, mem[28], mem[27], mem[26], mem[25], mem[24]}, 64'h000000009ABCDEF0);
`ifdef MISALIGN_CHECK_EN
      check("mem30_33", {32'h0, mem[33], mem[32], mem[31], mem[30]}, 64'h0);
`else
      check("mem30_33", {32'h0, mem[33], mem[32], mem[31], mem[30]}, 64'hA1B2C3D4);
`endif

      // Reset in the middle of a double store: three bytes land, the rest stay untouched.
      for (int i = 16; i < 24; i++) preload(6'(i), 8'h5A);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
      req_addr = 64'd16; req_wdata = 64'h0102030405060708;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk); @(posedge clk); @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_rst_we", {62'h0, mem_we, req_ready}, 64'h1);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_ready", {63'h0, req_ready}, 64'h1);
      busy_access = 0;
      for (int c = 0; c < 12; c++) begin
         if (resp_valid || mem_we || mem_re) busy_access++;
         @(negedge clk);
      end
      check("abort_quiet", 64'(busy_access), 64'h0);
      check("abort_mem", {mem[23], mem[22], mem[21], mem[20], mem[19], mem[18], mem[17], mem[16]},
            64'h5A5A5A5A5A060708);

      // Back-to-back: req_valid held through the busy window of a byte load.
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b1;
      req_addr = 64'd2; req_wdata = 64'h0;
      @(posedge clk);
      first_ready = 0; busy_access = 0; rsp1 = 64'hx;
      for (int c = 1; c <= 10 && first_ready == 0; c++) begin
         @(negedge clk);
         if (c == 1) begin
            req_write = 1'b1; req_addr = 64'd40; req_wdata = 64'h0000000000000099;
         end
         if (mem_we) busy_access++;
         if (resp_valid) rsp1 = resp_rdata;
         if (req_ready) first_ready = c;
      end
      check("b2b_ready_cycle", 64'(first_ready), 64'd3);
      check("b2b_load_rdata", rsp1, 64'h00000000000000F6);
      check("b2b_no_early_we", 64'(busy_access), 64'h0);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("b2b_store_access", {mem_we, mem_addr[6:0], mem_wdata}, {1'b1, 7'd40, 8'h99});
      @(negedge clk);
      check("b2b_store_resp", {resp_valid, resp_rdata[62:0]}, {1'b1, 63'h0});
      check("b2b_store_mem", {56'h0, mem[40]}, 64'h99);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
